// File: rtl/inc_dec_detector_p.sv
// ---------------------------------------------------------------------------
// inc_dec_detector_p
//
// Purpose:
//   Watches a qualified byte stream (one byte per cycle) and counts keyword
//   occurrences. "INC" increments the counter, "DEC" decrements it and, when
//   enabled, "CLR" zeroes the counter and both sticky flags. The counter can
//   wrap or saturate. Lowercase letters can optionally be folded to uppercase.
//   The block never back-pressures the stream.
//
// Handshake:
//   valid qualifies data. A byte is consumed on every rising edge where
//   valid=1. There is no ready signal, because the block always accepts. On
//   valid=0 cycles the history holds and no compare is made.
//
// Parameters:
//   CNT_W     counter width in bits (2..32)
//   SATURATE  0 = wrap modulo 2^CNT_W, 1 = clamp at 0 / 2^CNT_W-1
//   CASE_FOLD 1 = map 0x61..0x7A to 0x41..0x5A before storing/comparing
//   CLR_EN    1 = recognise "CLR", 0 = ignore it (hit_clr held at 0)
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-low reset
//   data     in   [7:0] streaming byte
//   valid    in   data qualifier
//   cnt      out  [CNT_W-1:0] keyword counter
//   hit_inc  out  one-cycle pulse after an "INC" match
//   hit_dec  out  one-cycle pulse after a "DEC" match
//   hit_clr  out  one-cycle pulse after a "CLR" match
//   ovf      out  sticky, an increment went past max
//   unf      out  sticky, a decrement went below zero
// ---------------------------------------------------------------------------
module inc_dec_detector_p #(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned SATURATE  = 0,
    parameter int unsigned CASE_FOLD = 0,
    parameter int unsigned CLR_EN    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       data,
    input  logic             valid,
    output logic [CNT_W-1:0] cnt,
    output logic             hit_inc,
    output logic             hit_dec,
    output logic             hit_clr,
    output logic             ovf,
    output logic             unf
);

    localparam logic [23:0]      KW_INC   = 24'h494E43;  // "INC"
    localparam logic [23:0]      KW_DEC   = 24'h444543;  // "DEC"
    localparam logic [23:0]      KW_CLR   = 24'h434C52;  // "CLR"
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Two-byte history: h1 is the older byte and h0 is the newer byte.
    logic [7:0]       h1_q, h1_d;
    logic [7:0]       h0_q, h0_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit_inc_q, hit_inc_d;
    logic             hit_dec_q, hit_dec_d;
    logic             hit_clr_q, hit_clr_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [7:0]       byte_f;
    logic [23:0]      window;
    logic             match_inc;
    logic             match_dec;
    logic             match_clr;

    // Case folding is applied before the byte is stored. The history
    // therefore always holds folded bytes, and a mixed-case keyword split by
    // gaps still matches.
    always_comb begin
        byte_f = data;
        if ((CASE_FOLD != 0) && (data >= 8'h61) && (data <= 8'h7A)) begin
            byte_f = data - 8'h20;
        end
    end

    assign window = {h1_q, h0_q, byte_f};

    // The keywords are distinct 3-byte strings. At most one of these can be
    // high in a cycle.
    assign match_inc = valid && (window == KW_INC);
    assign match_dec = valid && (window == KW_DEC);
    assign match_clr = valid && (CLR_EN != 0) && (window == KW_CLR);

    always_comb begin
        h1_d      = h1_q;
        h0_d      = h0_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        hit_inc_d = 1'b0;
        hit_dec_d = 1'b0;
        hit_clr_d = 1'b0;

        // The history keeps shifting after a match. No keyword overlaps
        // itself, so no flush is needed.
        if (valid) begin
            h1_d = h0_q;
            h0_d = byte_f;
        end

        if (match_inc) begin
            hit_inc_d = 1'b1;
            if (cnt_q == CNT_MAX) begin
                ovf_d = 1'b1;
                cnt_d = (SATURATE != 0) ? CNT_MAX : CNT_ZERO;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (match_dec) begin
            hit_dec_d = 1'b1;
            if (cnt_q == CNT_ZERO) begin
                unf_d = 1'b1;
                cnt_d = (SATURATE != 0) ? CNT_ZERO : CNT_MAX;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end else if (match_clr) begin
            hit_clr_d = 1'b1;
            cnt_d     = CNT_ZERO;
            ovf_d     = 1'b0;
            unf_d     = 1'b0;
        end
    end

    // Reset wins over a byte sampled on the same edge. A partial keyword
    // that is in flight across a reset is lost.
    always_ff @(posedge clk) begin
        if (!rst) begin
            h1_q      <= 8'h00;
            h0_q      <= 8'h00;
            cnt_q     <= CNT_ZERO;
            hit_inc_q <= 1'b0;
            hit_dec_q <= 1'b0;
            hit_clr_q <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            h1_q      <= h1_d;
            h0_q      <= h0_d;
            cnt_q     <= cnt_d;
            hit_inc_q <= hit_inc_d;
            hit_dec_q <= hit_dec_d;
            hit_clr_q <= hit_clr_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    assign cnt     = cnt_q;
    assign hit_inc = hit_inc_q;
    assign hit_dec = hit_dec_q;
    assign hit_clr = hit_clr_q;
    assign ovf     = ovf_q;
    assign unf     = unf_q;

endmodule

// File: tb/tb_inc_dec_detector_p.sv
// ---------------------------------------------------------------------------
// tb_inc_dec_detector_p
//
// Five instances share one stimulus stream. Each instance uses a different
// parameter set:
//   0: CNT_W=16 wrap,     no fold, CLR on
//   1: CNT_W=4  wrap,     no fold, CLR on
//   2: CNT_W=4  saturate, no fold, CLR on
//   3: CNT_W=16 wrap,     fold,    CLR on
//   4: CNT_W=16 wrap,     no fold, CLR off
// A per-instance reference model works directly from the keyword rules
// using integer arithmetic. It is compared against every output on every
// cycle. Directed phases add literal expectations.
// ---------------------------------------------------------------------------
module tb_inc_dec_detector_p;

    localparam int NI = 5;
    localparam int P_W   [NI] = '{16, 4, 4, 16, 16};
    localparam int P_SAT [NI] = '{0, 0, 1, 0, 0};
    localparam int P_CF  [NI] = '{0, 0, 0, 1, 0};
    localparam int P_CLR [NI] = '{1, 1, 1, 1, 0};

    localparam logic [23:0] S_INC  = 24'h494E43;
    localparam logic [23:0] S_DEC  = 24'h444543;
    localparam logic [23:0] S_CLR  = 24'h434C52;
    localparam logic [23:0] S_LINC = 24'h696E63;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       valid;

    logic [15:0] c0, c3, c4;
    logic [3:0]  c1, c2;
    logic        hi [NI];
    logic        hd [NI];
    logic        hc [NI];
    logic        ov [NI];
    logic        un [NI];

    int n_checks   = 0;
    int n_failures = 0;
    bit chk_en     = 1'b0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    inc_dec_detector_p #(.CNT_W(16), .SATURATE(0), .CASE_FOLD(0), .CLR_EN(1)) u0 (
        .clk(clk), .rst(rst), .data(data), .valid(valid), .cnt(c0),
        .hit_inc(hi[0]), .hit_dec(hd[0]), .hit_clr(hc[0]), .ovf(ov[0]), .unf(un[0]));
    inc_dec_detector_p #(.CNT_W(4), .SATURATE(0), .CASE_FOLD(0), .CLR_EN(1)) u1 (
        .clk(clk), .rst(rst), .data(data), .valid(valid), .cnt(c1),
        .hit_inc(hi[1]), .hit_dec(hd[1]), .hit_clr(hc[1]), .ovf(ov[1]), .unf(un[1]));
    inc_dec_detector_p #(.CNT_W(4), .SATURATE(1), .CASE_FOLD(0), .CLR_EN(1)) u2 (
        .clk(clk), .rst(rst), .data(data), .valid(valid), .cnt(c2),
        .hit_inc(hi[2]), .hit_dec(hd[2]), .hit_clr(hc[2]), .ovf(ov[2]), .unf(un[2]));
    inc_dec_detector_p #(.CNT_W(16), .SATURATE(0), .CASE_FOLD(1), .CLR_EN(1)) u3 (
        .clk(clk), .rst(rst), .data(data), .valid(valid), .cnt(c3),
        .hit_inc(hi[3]), .hit_dec(hd[3]), .hit_clr(hc[3]), .ovf(ov[3]), .unf(un[3]));
    inc_dec_detector_p #(.CNT_W(16), .SATURATE(0), .CASE_FOLD(0), .CLR_EN(0)) u4 (
        .clk(clk), .rst(rst), .data(data), .valid(valid), .cnt(c4),
        .hit_inc(hi[4]), .hit_dec(hd[4]), .hit_clr(hc[4]), .ovf(ov[4]), .unf(un[4]));

    // ---------------- reference model ----------------
    int         m_cnt [NI];
    logic [2:0] m_hit [NI];   // {inc, dec, clr}
    logic       m_ovf [NI];
    logic       m_unf [NI];
    logic [7:0] m_old [NI];   // last two accepted bytes, oldest first
    logic [7:0] m_new [NI];
    logic [7:0] m_b;
    int         m_top;
    int         m_nxt;

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            m_hit[i] = 3'b000;
            if (!rst) begin
                m_cnt[i] = 0;
                m_ovf[i] = 1'b0;
                m_unf[i] = 1'b0;
                m_old[i] = 8'h00;
                m_new[i] = 8'h00;
            end else if (valid) begin
                m_b = data;
                if (P_CF[i] != 0 && m_b >= 8'd97 && m_b <= 8'd122) m_b = m_b - 8'd32;
                m_top = (1 << P_W[i]) - 1;
                if ({m_old[i], m_new[i], m_b} == S_INC) begin
                    m_hit[i] = 3'b100;
                    m_nxt = m_cnt[i] + 1;
                    if (m_nxt > m_top) begin
                        m_ovf[i] = 1'b1;
                        m_nxt = (P_SAT[i] != 0) ? m_top : m_nxt - (m_top + 1);
                    end
                    m_cnt[i] = m_nxt;
                end else if ({m_old[i], m_new[i], m_b} == S_DEC) begin
                    m_hit[i] = 3'b010;
                    m_nxt = m_cnt[i] - 1;
                    if (m_nxt < 0) begin
                        m_unf[i] = 1'b1;
                        m_nxt = (P_SAT[i] != 0) ? 0 : m_nxt + m_top + 1;
                    end
                    m_cnt[i] = m_nxt;
                end else if (P_CLR[i] != 0 && {m_old[i], m_new[i], m_b} == S_CLR) begin
                    m_hit[i] = 3'b001;
                    m_cnt[i] = 0;
                    m_ovf[i] = 1'b0;
                    m_unf[i] = 1'b0;
                end
                m_old[i] = m_new[i];
                m_new[i] = m_b;
            end
        end
    end

    // ---------------- scoreboard ----------------
    function automatic logic [20:0] act_vec(input int i);
        logic [15:0] c;
        case (i)
            0:       c = c0;
            1:       c = {12'h000, c1};
            2:       c = {12'h000, c2};
            3:       c = c3;
            default: c = c4;
        endcase
        return {c, hi[i], hd[i], hc[i], ov[i], un[i]};
    endfunction

    function automatic logic [20:0] exp_vec(input int i);
        return {16'(m_cnt[i]), m_hit[i], m_ovf[i], m_unf[i]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                n_checks++;
                if (act_vec(i) !== exp_vec(i)) begin
                    n_failures++;
                    $display("FAIL model_cmp inst%0d at %0t: got {cnt,inc,dec,clr,ovf,unf}=%0h expected %0h",
                             i, $time, act_vec(i), exp_vec(i));
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Inputs are applied at a falling edge and held until the next falling
    // edge. Outputs for that byte are therefore readable on return.
    task automatic drive(input logic v, input logic [7:0] d, input logic r);
        valid = v;
        data  = d;
        rst   = r;
        @(negedge clk);
    endtask

    task automatic send3(input logic [23:0] kw);
        drive(1'b1, kw[23:16], 1'b1);
        drive(1'b1, kw[15:8], 1'b1);
        drive(1'b1, kw[7:0], 1'b1);
    endtask

    task automatic do_reset();
        drive(1'b0, 8'h00, 1'b0);
    endtask

    logic [7:0]  alpha [16] = '{8'h49, 8'h4E, 8'h43, 8'h44, 8'h45, 8'h4C, 8'h52, 8'h69,
                                8'h6E, 8'h63, 8'h64, 8'h65, 8'h6C, 8'h72, 8'h00, 8'h5A};
    logic [23:0] kws   [6]  = '{S_INC, S_DEC, S_CLR, S_LINC, 24'h646563, 24'h636C72};

    initial begin
        rst = 1'b0;
        valid = 1'b0;
        data = 8'h00;
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0);
        chk_en = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        chk("reset_cnt", 32'(c0), 32'h0);
        chk("reset_flags", {30'h0, ov[0], un[0]}, 32'h0);

        // Default stream with gaps.
        drive(1'b1, 8'h49, 1'b1);
        drive(1'b1, 8'h4E, 1'b1);
        drive(1'b1, 8'h43, 1'b1);
        chk("p1_cnt_after_inc", 32'(c0), 32'h1);
        chk("p1_hit_inc", 32'(hi[0]), 32'h1);
        drive(1'b0, 8'h69, 1'b1);
        chk("p1_pulse_one_cycle", 32'(hi[0]), 32'h0);
        drive(1'b1, 8'h44, 1'b1);
        drive(1'b1, 8'h45, 1'b1);
        drive(1'b1, 8'h43, 1'b1);
        chk("p1_cnt_after_dec", 32'(c0), 32'h0);
        chk("p1_hit_dec", 32'(hd[0]), 32'h1);
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b1, 8'h45, 1'b1);
        drive(1'b1, 8'h43, 1'b1);
        drive(1'b1, 8'h00, 1'b1);
        chk("p1_flags", {30'h0, ov[0], un[0]}, 32'h0);

        // 4-bit wrap and saturate.
        do_reset();
        for (int k = 0; k < 16; k++) begin
            send3(S_INC);
            chk("w_inc_walk", 32'(c1), 32'((k + 1) & 15));
        end
        chk("w_ovf", 32'(ov[1]), 32'h1);
        chk("s_clamp_15", 32'(c2), 32'd15);
        chk("s_ovf", 32'(ov[2]), 32'h1);
        send3(S_DEC);
        chk("w_dec_wrap", 32'(c1), 32'd15);
        chk("w_unf", 32'(un[1]), 32'h1);

        do_reset();
        for (int k = 0; k < 17; k++) send3(S_INC);
        chk("s_hold_15", 32'(c2), 32'd15);
        for (int k = 0; k < 16; k++) begin
            send3(S_DEC);
            chk("s_dec_walk", 32'(c2), 32'((14 - k) < 0 ? 0 : (14 - k)));
        end
        chk("s_unf", 32'(un[2]), 32'h1);

        // Case folding.
        do_reset();
        send3(S_LINC);
        chk("fold_cnt", 32'(c3), 32'h1);
        chk("fold_hit", 32'(hi[3]), 32'h1);
        chk("nofold_cnt", 32'(c0), 32'h0);
        chk("nofold_hit", 32'(hi[0]), 32'h0);

        // CLR clears the counter and flags. With CLR off, the keyword is ignored.
        do_reset();
        send3(S_DEC);
        chk("clr_pre_wrap", 32'(c0), 32'hFFFF);
        send3(S_INC);
        send3(S_INC);
        send3(S_INC);
        chk("clr_pre_cnt", 32'(c0), 32'h2);
        chk("clr_pre_flags", {30'h0, ov[0], un[0]}, 32'h3);
        send3(S_CLR);
        chk("clr_cnt", 32'(c0), 32'h0);
        chk("clr_hit", 32'(hc[0]), 32'h1);
        chk("clr_flags", {30'h0, ov[0], un[0]}, 32'h0);
        chk("clr_off_cnt", 32'(c4), 32'h2);
        chk("clr_off_hit", 32'(hc[4]), 32'h0);
        chk("clr_off_flags", {30'h0, ov[4], un[4]}, 32'h3);

        // Reset in the middle of a keyword.
        do_reset();
        drive(1'b1, 8'h49, 1'b1);
        drive(1'b1, 8'h4E, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b1, 8'h43, 1'b1);
        chk("rst_mid_cnt", 32'(c0), 32'h0);
        chk("rst_mid_hit", 32'(hi[0]), 32'h0);
        drive(1'b1, 8'h49, 1'b1);
        drive(1'b1, 8'h4E, 1'b1);
        drive(1'b1, 8'h43, 1'b0);
        chk("rst_prio_cnt", 32'(c0), 32'h0);
        chk("rst_prio_hit", 32'(hi[0]), 32'h0);
        send3(S_INC);
        chk("post_rst_inc", 32'(c0), 32'h1);

        // Randomised traffic.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 7) == 0) begin
                send3(kws[$urandom_range(0, 5)]);
            end else begin
                drive(($urandom_range(0, 3) != 0), alpha[$urandom_range(0, 15)], 1'b1);
            end
        end

        drive(1'b0, 8'h00, 1'b1);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule

// File: doc/inc_dec_detector_p.md
# inc_dec_detector_p

Parametrised successor to the byte-stream keyword counter. The block watches a 1-byte-per-cycle qualified stream and counts keyword occurrences: ASCII "INC" increments the counter and "DEC" decrements it. An optional "CLR" keyword zeroes the counter. Counter width, wrap vs. saturate, and case folding are configurable, and the block adds registered hit pulses plus sticky overflow/underflow flags. It sits directly on the streaming data path and needs no flow control; it never back-pressures.

## Interface
Parameters:
- CNT_W, 16, counter width in bits (legal range 2–32)
- SATURATE, 0, 0 = counter wraps modulo 2^CNT_W; 1 = counter clamps at 0 / 2^CNT_W-1
- CASE_FOLD, 0, 1 = bytes 0x61–0x7A are mapped to 0x41–0x5A before storing and comparing
- CLR_EN, 1, 1 = the "CLR" keyword (0x43 0x4C 0x52) is recognised; 0 = it is ignored

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  reset, synchronous, active-low (rst=0 resets on the next rising clk edge)
- data  input  8  streaming byte
- valid  input  1  high when data is valid; bytes with valid=0 are ignored entirely
- cnt  output  CNT_W  keyword counter
- hit_inc  output  1  one-cycle pulse, "INC" matched
- hit_dec  output  1  one-cycle pulse, "DEC" matched
- hit_clr  output  1  one-cycle pulse, "CLR" matched (held at 0 when CLR_EN=0)
- ovf  output  1  sticky, set on increment past max (wrap or clamp)
- unf  output  1  sticky, set on decrement below 0 (wrap or clamp)

## Operation
- History: a 2-byte shift register h1 (older) and h0 (newer). Its reset value is 0x00 in both bytes.
- On a valid=1 cycle the byte b (case-folded if CASE_FOLD=1) is used as follows:
  - Compare {h1,h0,b} against the keywords.
  - Shift the history: h1<=h0, h0<=b.
  - Shifting continues after a match; keywords cannot self-overlap, so no reset of history is needed.
- On a valid=0 cycle the history holds and no compare occurs. Gaps therefore do not break a keyword: "IN", gap, "C" counts.
- Any non-matching valid byte breaks a partial match. This includes a lowercase byte when CASE_FOLD=0.
- On a match, exactly one keyword can match per cycle:
  - INC: if cnt=max, then wrap to 0 (SATURATE=0) or hold max (SATURATE=1), and set ovf; otherwise cnt+1.
  - DEC: if cnt=0, then wrap to max (SATURATE=0) or hold 0 (SATURATE=1), and set unf; otherwise cnt-1.
  - CLR (CLR_EN=1): cnt<=0, ovf<=0, unf<=0. A CLR match clears the flags.
- ovf and unf stay set until reset or a CLR match.
- Arithmetic is unsigned CNT_W-bit; max = 2^CNT_W-1.

## Timing
- Reset (rst=0 at an edge) sets cnt=0, hit_*=0, ovf=0, unf=0, and h1=h0=0x00. Reset takes priority over a simultaneous valid byte or match.
- Latency: the third keyword byte is sampled at edge N. At that same edge N, cnt, the hit pulse, and the flags update, so they are visible in cycle N+1.
- hit_* are high for exactly one cycle after each match and low otherwise. Back-to-back keywords ("INCINC", 6 consecutive valid bytes) give two pulses spaced 3 cycles apart.
- Reset mid-keyword discards the partial history. "IN", reset, "C" produces no match.
- Outputs are all registered; there is no combinational path from data or valid to any output.

## Test plan
- Default params: rst low 2 cycles, then a valid stream with gaps: 49 4E 43, (valid=0, 69), 44 45 43, valid=0 gap, 45 43 00. Required: cnt=0x0001 one cycle after the first 43, then cnt=0x0000 one cycle after the second 43; hit_inc and hit_dec pulse once each; ovf=unf=0.
- CNT_W=4, SATURATE=0: 16×"INC" -> cnt walks 1..15 then 0, with ovf=1 after the 16th; then "DEC" -> cnt=15 and unf=1.
- CNT_W=4, SATURATE=1: 17×"INC" -> cnt holds 15 and ovf=1; then 16×"DEC" -> cnt=0 and unf=1, and cnt never wraps.
- CASE_FOLD=1: "inc" (69 6E 63) -> cnt=1; the same stream with CASE_FOLD=0 -> cnt=0 and no hit.
- CLR: drive "INC", "INC", then "CLR" -> cnt=2 then 0, hit_clr pulses, flags cleared. With CLR_EN=0 the same stream -> cnt=2 and hit_clr=0.
- Reset mid-keyword: "I","N", rst=0 for 1 cycle, then "C" -> cnt=0 and no hit. Then "INC" with rst=0 on the third byte's edge -> cnt stays 0.
